id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the pipelined MIPS core, directly upstream of EX; feeds ALU_Control (EX_ALUOp, EX_func) and the ALU.
- Registers decoded control and operands each cycle.
- Detects load-use hazards against the instruction currently in EX and inserts a bubble.
- Supports external hold (stall) and flush (branch/jump squash), with a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, width of PC+4, register operands and extended immediate
CNT_W, 16, width of the saturating bubble counter

Ports:
CLK  in  1  rising-edge clock
RST_n  in  1  reset, asynchronous, active-low
Stall  in  1  hold request from a later stage; register keeps its contents
Flush  in  1  squash the ID instruction; a bubble enters EX
ID_Valid  in  1  ID slot holds a real instruction
ID_PC4  in  DATA_W  PC+4 of the ID instruction
ID_ReadData1  in  DATA_W  rs operand
ID_ReadData2  in  DATA_W  rt operand
ID_ExtImm  in  DATA_W  sign/zero-extended immediate
ID_rs, ID_rt, ID_rd  in  5 each  register specifiers
ID_sa  in  5  shift amount
ID_func  in  6  function field
ID_ALUOp  in  4  ALU operation class (4'b1000 = R-type)
ID_UsesRt  in  1  ID instruction reads rt as a source
ID_RegDst, ID_ALUSrcB, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_RegWrite  in  1 each  control bits
EX_* (same names, EX_ prefix, including EX_Valid)  out  same widths  registered copies
LoadUse_Stall  out  1  combinational; freezes PC and IF/ID
BubbleCount  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (RST_n=0, asynchronous): all EX_* outputs = 0, so EX_ALUOp = 4'b0000 (ADD) and EX_Valid = 0. BubbleCount = 0. Reset overrides everything, including mid-stall and mid-bubble.
- LoadUse_Stall is high when all of the following hold:
  - EX_Valid & EX_MemRead & ID_Valid & (EX_rt != 0);
  - (EX_rt == ID_rs) or (ID_UsesRt & EX_rt == ID_rt).
- LoadUse_Stall is forced to 0 when Flush or Stall is high.
- Update priority on each rising edge, highest first:
  1. Flush = 1 -> load a bubble.
  2. Stall = 1 -> hold all EX_* unchanged.
  3. LoadUse_Stall = 1 -> load a bubble. The ID instruction stays in IF/ID and is accepted next cycle, because EX_MemRead is then 0.
  4. Otherwise -> EX_* <= ID_* (one-cycle latency).
- Bubble: every EX_* field = 0. That gives EX_Valid = 0, RegWrite/MemRead/MemWrite = 0, EX_ALUOp = 4'b0000, EX_func = 6'b000000.
- Loading with ID_Valid = 0 (case 4) copies the inputs but forces RegWrite, MemRead and MemWrite to 0.
- BubbleCount increments by 1 on each edge taking case 1 or case 3.
  - Counts even if the flushed ID slot was already invalid.
  - Holds at 2^CNT_W-1 (no wrap).
  - Unchanged on hold and normal load.
- Stall and Flush together: Flush wins (squash beats hold).
- No storage other than the EX_* fields and BubbleCount. Width rules are pass-through; no arithmetic on the datapath.

Test Plan:
- Reset then normal flow: RST_n low 2 cycles; all EX_* = 0 and BubbleCount = 0. Release; present an ADD (ID_ALUOp = 4'b1000, ID_func = 6'b100000, ID_ReadData1 = 5, ID_ReadData2 = 7, ID_RegWrite = 1, ID_Valid = 1) -> next edge EX_ALUOp = 4'b1000, EX_func = 6'b100000, EX_ReadData1 = 5, EX_RegWrite = 1.
- Load-use:
  - Cycle n: EX holds lw with EX_MemRead = 1, EX_rt = 8. ID holds an instruction with ID_rs = 8 -> LoadUse_Stall = 1 in cycle n.
  - Next edge: EX_Valid = 0, EX_ALUOp = 0, BubbleCount = 1.
  - Same ID instruction next cycle: LoadUse_Stall = 0; it loads on the following edge.
- Load-use exclusions:
  - EX_rt = 0 with ID_rs = 0 -> no stall.
  - ID_rt = 8 with ID_UsesRt = 0 (e.g. ADDI, ID_ALUOp = 4'b0000) -> no stall.
  - ID_rt = 8 with ID_UsesRt = 1 (BEQ, ID_ALUOp = 4'b0001) -> stall.
- Hold and flush:
  - Stall = 1 for 3 cycles while ID inputs change -> EX_* constant, BubbleCount unchanged.
  - Stall = 1 and Flush = 1 together -> bubble loaded, BubbleCount + 1.
  - Flush during an active load-use -> single bubble, BubbleCount + 1 only.
- Saturation and async reset: with CNT_W = 2, force 5 bubbles -> BubbleCount sticks at 3. Drop RST_n mid-cycle between edges -> outputs clear immediately, without waiting for CLK.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: one cycle from ID_* to EX_*; LoadUse_Stall is combinational in the same cycle.
// Backpressure: Stall holds the register, Flush or a load-use hazard loads a bubble.
//
// Ports:
//   CLK, RST_n             rising-edge clock, asynchronous active-low reset
//   Stall, Flush           hold request from later stages / squash of the ID slot
//   ID_*                   decoded instruction, operands and control bits from ID
//   EX_*                   registered copies presented to ALU_Control and the ALU
//   LoadUse_Stall          freezes PC and IF/ID while a bubble is inserted
//   BubbleCount            bubbles inserted since reset, saturating at all-ones
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_ExtImm,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic [4:0]        ID_rd,
  input  logic [4:0]        ID_sa,
  input  logic [5:0]        ID_func,
  input  logic [3:0]        ID_ALUOp,
  input  logic              ID_UsesRt,
  input  logic              ID_RegDst,
  input  logic              ID_ALUSrcB,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_RegWrite,
  output logic              EX_Valid,
  output logic [DATA_W-1:0] EX_PC4,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_ExtImm,
  output logic [4:0]        EX_rs,
  output logic [4:0]        EX_rt,
  output logic [4:0]        EX_rd,
  output logic [4:0]        EX_sa,
  output logic [5:0]        EX_func,
  output logic [3:0]        EX_ALUOp,
  output logic              EX_UsesRt,
  output logic              EX_RegDst,
  output logic              EX_ALUSrcB,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg,
  output logic              EX_RegWrite,
  output logic              LoadUse_Stall,
  output logic [CNT_W-1:0]  BubbleCount
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] ext_imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sa;
    logic [5:0]        func;
    logic [3:0]        alu_op;
    logic              uses_rt;
    logic              reg_dst;
    logic              alu_src_b;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
  } stage_t;

  stage_t            stage_q, stage_d, id_dat;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard;
  logic              bubble;

  // An invalid ID slot still passes its fields through, but must never
  // commit architectural state downstream.
  always_comb begin
    id_dat            = '{
      valid:      ID_Valid,
      pc4:        ID_PC4,
      rd1:        ID_ReadData1,
      rd2:        ID_ReadData2,
      ext_imm:    ID_ExtImm,
      rs:         ID_rs,
      rt:         ID_rt,
      rd:         ID_rd,
      sa:         ID_sa,
      func:       ID_func,
      alu_op:     ID_ALUOp,
      uses_rt:    ID_UsesRt,
      reg_dst:    ID_RegDst,
      alu_src_b:  ID_ALUSrcB,
      mem_read:   ID_MemRead & ID_Valid,
      mem_write:  ID_MemWrite & ID_Valid,
      mem_to_reg: ID_MemToReg,
      reg_write:  ID_RegWrite & ID_Valid
    };
  end

  // Load in EX whose destination is a source of the ID instruction. $zero is
  // never a real dependency. Suppressed under Flush/Stall: a squashed or
  // held ID instruction must not freeze the front end.
  assign hazard = stage_q.valid & stage_q.mem_read & ID_Valid & (stage_q.rt != 5'd0) &
                  ((stage_q.rt == ID_rs) | (ID_UsesRt & (stage_q.rt == ID_rt)));
  assign LoadUse_Stall = hazard & ~Flush & ~Stall;

  // Flush beats Stall; a load-use bubble only happens when neither is set.
  assign bubble = Flush | LoadUse_Stall;

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (bubble) begin
      stage_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!Stall) begin
      stage_d = id_dat;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EX_Valid     = stage_q.valid;
  assign EX_PC4       = stage_q.pc4;
  assign EX_ReadData1 = stage_q.rd1;
  assign EX_ReadData2 = stage_q.rd2;
  assign EX_ExtImm    = stage_q.ext_imm;
  assign EX_rs        = stage_q.rs;
  assign EX_rt        = stage_q.rt;
  assign EX_rd        = stage_q.rd;
  assign EX_sa        = stage_q.sa;
  assign EX_func      = stage_q.func;
  assign EX_ALUOp     = stage_q.alu_op;
  assign EX_UsesRt    = stage_q.uses_rt;
  assign EX_RegDst    = stage_q.reg_dst;
  assign EX_ALUSrcB   = stage_q.alu_src_b;
  assign EX_MemRead   = stage_q.mem_read;
  assign EX_MemWrite  = stage_q.mem_write;
  assign EX_MemToReg  = stage_q.mem_to_reg;
  assign EX_RegWrite  = stage_q.reg_write;
  assign BubbleCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [3:0]  alu_op;
    logic        uses_rt;
    logic        reg_dst;
    logic        alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
  } st_t;

  typedef struct {
    bit          stall;
    bit          flush;
    st_t         id;
    bit          e_lu;
    bit          e_valid;
    logic [3:0]  e_alu;
    bit          e_mr;
    bit          e_rw;
    logic [31:0] e_rd1;
    int          e_cnt;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_n;
  logic Stall, Flush;
  st_t  id_in;

  logic        a_valid, a_uses, a_rdst, a_srcb, a_mr, a_mw, a_m2r, a_rw, a_lu;
  logic [31:0] a_pc4, a_rd1, a_rd2, a_imm;
  logic [4:0]  a_rs, a_rt, a_rd, a_sa;
  logic [5:0]  a_func;
  logic [3:0]  a_alu;
  logic [15:0] a_cnt;
  logic        b_valid, b_uses, b_rdst, b_srcb, b_mr, b_mw, b_m2r, b_rw, b_lu;
  logic [31:0] b_pc4, b_rd1, b_rd2, b_imm;
  logic [4:0]  b_rs, b_rt, b_rd, b_sa;
  logic [5:0]  b_func;
  logic [3:0]  b_alu;
  logic [1:0]  b_cnt;
  st_t dut_a, dut_b;

  int checks = 0;
  int failures = 0;

  st_t m_ex;
  int  ma_cnt, mb_cnt;
  bit  m_lu;

  always #5 CLK = ~CLK;

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(16)) u_dut (
    .CLK(CLK), .RST_n(RST_n), .Stall(Stall), .Flush(Flush),
    .ID_Valid(id_in.valid), .ID_PC4(id_in.pc4), .ID_ReadData1(id_in.rd1),
    .ID_ReadData2(id_in.rd2), .ID_ExtImm(id_in.imm), .ID_rs(id_in.rs), .ID_rt(id_in.rt),
    .ID_rd(id_in.rd), .ID_sa(id_in.sa), .ID_func(id_in.func), .ID_ALUOp(id_in.alu_op),
    .ID_UsesRt(id_in.uses_rt), .ID_RegDst(id_in.reg_dst), .ID_ALUSrcB(id_in.alu_src_b),
    .ID_MemRead(id_in.mem_read), .ID_MemWrite(id_in.mem_write),
    .ID_MemToReg(id_in.mem_to_reg), .ID_RegWrite(id_in.reg_write),
    .EX_Valid(a_valid), .EX_PC4(a_pc4), .EX_ReadData1(a_rd1), .EX_ReadData2(a_rd2),
    .EX_ExtImm(a_imm), .EX_rs(a_rs), .EX_rt(a_rt), .EX_rd(a_rd), .EX_sa(a_sa),
    .EX_func(a_func), .EX_ALUOp(a_alu), .EX_UsesRt(a_uses), .EX_RegDst(a_rdst),
    .EX_ALUSrcB(a_srcb), .EX_MemRead(a_mr), .EX_MemWrite(a_mw), .EX_MemToReg(a_m2r),
    .EX_RegWrite(a_rw), .LoadUse_Stall(a_lu), .BubbleCount(a_cnt)
  );

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(2)) u_dut_sat (
    .CLK(CLK), .RST_n(RST_n), .Stall(Stall), .Flush(Flush),
    .ID_Valid(id_in.valid), .ID_PC4(id_in.pc4), .ID_ReadData1(id_in.rd1),
    .ID_ReadData2(id_in.rd2), .ID_ExtImm(id_in.imm), .ID_rs(id_in.rs), .ID_rt(id_in.rt),
    .ID_rd(id_in.rd), .ID_sa(id_in.sa), .ID_func(id_in.func), .ID_ALUOp(id_in.alu_op),
    .ID_UsesRt(id_in.uses_rt), .ID_RegDst(id_in.reg_dst), .ID_ALUSrcB(id_in.alu_src_b),
    .ID_MemRead(id_in.mem_read), .ID_MemWrite(id_in.mem_write),
    .ID_MemToReg(id_in.mem_to_reg), .ID_RegWrite(id_in.reg_write),
    .EX_Valid(b_valid), .EX_PC4(b_pc4), .EX_ReadData1(b_rd1), .EX_ReadData2(b_rd2),
    .EX_ExtImm(b_imm), .EX_rs(b_rs), .EX_rt(b_rt), .EX_rd(b_rd), .EX_sa(b_sa),
    .EX_func(b_func), .EX_ALUOp(b_alu), .EX_UsesRt(b_uses), .EX_RegDst(b_rdst),
    .EX_ALUSrcB(b_srcb), .EX_MemRead(b_mr), .EX_MemWrite(b_mw), .EX_MemToReg(b_m2r),
    .EX_RegWrite(b_rw), .LoadUse_Stall(b_lu), .BubbleCount(b_cnt)
  );

  assign dut_a = {a_valid, a_pc4, a_rd1, a_rd2, a_imm, a_rs, a_rt, a_rd, a_sa, a_func,
                  a_alu, a_uses, a_rdst, a_srcb, a_mr, a_mw, a_m2r, a_rw};
  assign dut_b = {b_valid, b_pc4, b_rd1, b_rd2, b_imm, b_rs, b_rt, b_rd, b_sa, b_func,
                  b_alu, b_uses, b_rdst, b_srcb, b_mr, b_mw, b_m2r, b_rw};

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic st_t mk(input bit v, input int rs, input int rt, input bit uses,
                             input int alu, input int func, input bit mr, input bit rw,
                             input int rd1);
    st_t s;
    s           = '0;
    s.valid     = v;
    s.rs        = 5'(rs);
    s.rt        = 5'(rt);
    s.uses_rt   = uses;
    s.alu_op    = 4'(alu);
    s.func      = 6'(func);
    s.mem_read  = mr;
    s.reg_write = rw;
    s.rd1       = 32'(rd1);
    s.rd2       = 32'd7;
    s.pc4       = 32'h0040_0000 + 32'(rd1 * 4);
    s.imm       = 32'(rd1) ^ 32'h0000_ffff;
    s.rd        = 5'(rd1 + 3);
    s.sa        = 5'd3;
    s.mem_to_reg = mr;
    s.alu_src_b = mr;
    s.reg_dst   = ~mr;
    return s;
  endfunction

  function automatic vec_t v(input bit st, input bit fl, input st_t id, input bit lu,
                             input bit ev, input int ealu, input bit emr, input bit erw,
                             input int erd1, input int ecnt);
    vec_t r;
    r.stall = st; r.flush = fl; r.id = id; r.e_lu = lu; r.e_valid = ev;
    r.e_alu = 4'(ealu); r.e_mr = emr; r.e_rw = erw; r.e_rd1 = 32'(erd1); r.e_cnt = ecnt;
    return r;
  endfunction

  // Reference behaviour: stall rule evaluated on the model's own EX contents,
  // then the priority Flush > Stall > load-use > load.
  function automatic bit ref_lu();
    bit dep;
    dep = (m_ex.rt == id_in.rs) || (id_in.uses_rt && m_ex.rt == id_in.rt);
    return m_ex.valid && m_ex.mem_read && id_in.valid && m_ex.rt != 0 && dep &&
           !Flush && !Stall;
  endfunction

  task automatic model_edge(input bit lu);
    if (Flush || lu) begin
      m_ex   = '0;
      ma_cnt = (ma_cnt < 65535) ? ma_cnt + 1 : ma_cnt;
      mb_cnt = (mb_cnt < 3) ? mb_cnt + 1 : mb_cnt;
    end else if (!Stall) begin
      m_ex = id_in;
      if (!id_in.valid) begin
        m_ex.reg_write = 1'b0;
        m_ex.mem_read  = 1'b0;
        m_ex.mem_write = 1'b0;
      end
    end
  endtask

  // Called at posedge+1 with inputs already applied.
  task automatic step();
    #1;
    m_lu = ref_lu();
    chk("loaduse", 256'(a_lu), 256'(m_lu));
    chk("loaduse_sat", 256'(b_lu), 256'(m_lu));
    @(posedge CLK);
    model_edge(m_lu);
    #1;
    chk("ex_state", 256'(dut_a), 256'(m_ex));
    chk("ex_state_sat", 256'(dut_b), 256'(m_ex));
    chk("bubble_cnt", 256'(a_cnt), 256'(ma_cnt));
    chk("bubble_cnt_sat", 256'(b_cnt), 256'(mb_cnt));
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    m_ex = '0; ma_cnt = 0; mb_cnt = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("reset_ex", 256'(dut_a), 256'(0));
    chk("reset_cnt", 256'(a_cnt), 256'(0));
    chk("reset_cnt_sat", 256'(b_cnt), 256'(0));
    RST_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[$];
    st_t  add_i, ld_h, beq_i;

    RST_n = 1'b0; Stall = 1'b0; Flush = 1'b0; id_in = '0;
    do_reset();

    add_i = mk(1, 8, 9, 1, 8, 32, 0, 1, 11);
    beq_i = mk(1, 5, 8, 1, 1, 0, 0, 0, 14);
    ld_h  = mk(1, 8, 2, 1, 8, 32, 0, 1, 15);
    vecs.push_back(v(0, 0, mk(1, 1, 2, 1, 8, 32, 0, 1, 5),   0, 1, 8, 0, 1, 5,   0));
    vecs.push_back(v(0, 0, mk(1, 3, 8, 0, 0, 0, 1, 1, 100),  0, 1, 0, 1, 1, 100, 0));
    vecs.push_back(v(0, 0, add_i,                            1, 0, 0, 0, 0, 0,   1));
    vecs.push_back(v(0, 0, add_i,                            0, 1, 8, 0, 1, 11,  1));
    vecs.push_back(v(0, 0, mk(1, 4, 0, 0, 0, 0, 1, 1, 200),  0, 1, 0, 1, 1, 200, 1));
    vecs.push_back(v(0, 0, mk(1, 0, 0, 1, 8, 32, 0, 1, 12),  0, 1, 8, 0, 1, 12,  1));
    vecs.push_back(v(0, 0, mk(1, 4, 8, 0, 0, 0, 1, 1, 300),  0, 1, 0, 1, 1, 300, 1));
    vecs.push_back(v(0, 0, mk(1, 5, 8, 0, 0, 0, 0, 1, 13),   0, 1, 0, 0, 1, 13,  1));
    vecs.push_back(v(0, 0, mk(1, 4, 8, 0, 0, 0, 1, 1, 301),  0, 1, 0, 1, 1, 301, 1));
    vecs.push_back(v(0, 0, beq_i,                            1, 0, 0, 0, 0, 0,   2));
    vecs.push_back(v(0, 0, beq_i,                            0, 1, 1, 0, 0, 14,  2));
    vecs.push_back(v(0, 0, mk(1, 4, 8, 0, 0, 0, 1, 1, 302),  0, 1, 0, 1, 1, 302, 2));
    vecs.push_back(v(1, 0, ld_h,                             0, 1, 0, 1, 1, 302, 2));
    vecs.push_back(v(1, 0, mk(1, 1, 2, 1, 8, 32, 0, 1, 16),  0, 1, 0, 1, 1, 302, 2));
    vecs.push_back(v(1, 0, mk(1, 8, 2, 1, 8, 32, 0, 1, 17),  0, 1, 0, 1, 1, 302, 2));
    vecs.push_back(v(1, 1, mk(1, 8, 2, 1, 8, 32, 0, 1, 18),  0, 0, 0, 0, 0, 0,   3));
    vecs.push_back(v(0, 0, mk(1, 4, 8, 0, 0, 0, 1, 1, 303),  0, 1, 0, 1, 1, 303, 3));
    vecs.push_back(v(0, 1, mk(1, 8, 2, 1, 8, 32, 0, 1, 19),  0, 0, 0, 0, 0, 0,   4));
    vecs.push_back(v(0, 0, mk(0, 1, 2, 1, 8, 32, 1, 1, 20),  0, 0, 8, 0, 0, 20,  4));

    foreach (vecs[i]) begin
      Stall = vecs[i].stall;
      Flush = vecs[i].flush;
      id_in = vecs[i].id;
      #1;
      chk($sformatf("vec%0d_lu", i), 256'(a_lu), 256'(vecs[i].e_lu));
      @(posedge CLK);
      model_edge(vecs[i].e_lu);
      #1;
      chk($sformatf("vec%0d_valid", i), 256'(a_valid), 256'(vecs[i].e_valid));
      chk($sformatf("vec%0d_aluop", i), 256'(a_alu), 256'(vecs[i].e_alu));
      chk($sformatf("vec%0d_memread", i), 256'(a_mr), 256'(vecs[i].e_mr));
      chk($sformatf("vec%0d_regwrite", i), 256'(a_rw), 256'(vecs[i].e_rw));
      chk($sformatf("vec%0d_rd1", i), 256'(a_rd1), 256'(vecs[i].e_rd1));
      chk($sformatf("vec%0d_cnt", i), 256'(a_cnt), 256'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_cnt_sat", i), 256'(b_cnt),
          256'((vecs[i].e_cnt > 3) ? 3 : vecs[i].e_cnt));
      chk($sformatf("vec%0d_full", i), 256'(dut_a), 256'(m_ex));
    end

    // Saturation: five flushes on the narrow counter stick at 3.
    Stall = 1'b0; Flush = 1'b0;
    do_reset();
    Flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      id_in = mk(1, k, k + 1, 1, 8, 32, 0, 1, 40 + k);
      step();
    end
    chk("sat_narrow", 256'(b_cnt), 256'(3));
    chk("sat_wide", 256'(a_cnt), 256'(5));

    // Asynchronous reset between edges clears without a clock edge.
    Flush = 1'b0;
    id_in = mk(1, 4, 8, 0, 0, 0, 1, 1, 77);
    step();
    id_in = mk(1, 8, 9, 1, 8, 32, 0, 1, 78);
    #2;
    RST_n = 1'b0;
    #1;
    chk("async_rst_ex", 256'(dut_a), 256'(0));
    chk("async_rst_cnt", 256'(a_cnt), 256'(0));
    chk("async_rst_lu", 256'(a_lu), 256'(0));
    m_ex = '0; ma_cnt = 0; mb_cnt = 0;
    @(posedge CLK);
    #1;
    RST_n = 1'b1;

    // Randomized traffic against the reference model; small register
    // numbers keep load-use hazards frequent.
    for (int n = 0; n < 400; n++) begin
      st_t r;
      r           = '0;
      r.valid     = ($urandom_range(7) != 0);
      r.pc4       = $urandom;
      r.rd1       = $urandom;
      r.rd2       = $urandom;
      r.imm       = $urandom;
      r.rs        = 5'($urandom_range(3));
      r.rt        = 5'($urandom_range(3));
      r.rd        = 5'($urandom);
      r.sa        = 5'($urandom);
      r.func      = 6'($urandom);
      r.alu_op    = 4'($urandom);
      r.uses_rt   = 1'($urandom);
      r.reg_dst   = 1'($urandom);
      r.alu_src_b = 1'($urandom);
      r.mem_read  = 1'($urandom);
      r.mem_write = 1'($urandom);
      r.mem_to_reg = 1'($urandom);
      r.reg_write = 1'($urandom);
      id_in = r;
      Stall = ($urandom_range(7) == 0);
      Flush = ($urandom_range(11) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
